// File: rtl/axilite_m_queued.sv
// axilite_m_queued: AXI4-Lite master running queued read/write commands in order, one completion each, with a wait-state timeout
module axilite_m_queued #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } cmd_t;
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} st_t;
  cmd_t mem_q [DEPTH];
  cmd_t cur_q;
  st_t st_q;
  logic [AW:0] wp_q, rp_q;
  logic [31:0] cnt_q;
  logic issue_q, aw_done_q, w_done_q;
  logic full, empty, push, pop, aw_fin, w_fin, adv, wait_st, tmo_exit;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  assign cmd_ready = m_axi_aresetn && !full;
  assign push = cmd_valid && cmd_ready;
  // issue_q marks a popped command waiting one cycle before its AXI valids rise
  assign pop = (st_q == IDLE) && !issue_q && !empty;
  assign busy = (st_q != IDLE) || issue_q || !empty;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign aw_fin = aw_done_q || (m_axi_awvalid && m_axi_awready);
  assign w_fin = w_done_q || (m_axi_wvalid && m_axi_wready);
  assign wait_st = st_q inside {WR, WR_B, RD_AR, RD_R};
  assign adv = (st_q == WR) ? aw_fin && w_fin :
               (st_q == WR_B) ? m_axi_bvalid :
               (st_q == RD_AR) ? m_axi_arready : m_axi_rvalid;
  assign tmo_exit = wait_st && !adv && (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
  always_ff @(posedge m_axi_aclk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= '{cmd_we, cmd_addr, cmd_wdata, cmd_wstrb};
  end
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + (AW+1)'(1);
      if (pop) rp_q <= rp_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      st_q <= IDLE;
      issue_q <= 1'b0;
      cur_q <= '0;
      cnt_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata <= '0;
      m_axi_wstrb <= '0;
      m_axi_araddr <= '0;
      rsp_valid <= 1'b0;
      rsp_we <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      case (st_q)
        IDLE: begin
          if (issue_q) begin
            issue_q <= 1'b0;
            cnt_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            st_q <= cur_q.we ? WR : RD_AR;
            m_axi_awvalid <= cur_q.we;
            m_axi_wvalid <= cur_q.we;
            m_axi_arvalid <= !cur_q.we;
            if (cur_q.we) begin
              m_axi_awaddr <= cur_q.addr;
              m_axi_wdata <= cur_q.wdata;
              m_axi_wstrb <= cur_q.wstrb;
            end else m_axi_araddr <= cur_q.addr;
          end else if (pop) begin
            cur_q <= mem_q[rp_q[AW-1:0]];
            issue_q <= 1'b1;
          end
        end
        WR: begin
          aw_done_q <= aw_fin;
          w_done_q <= w_fin;
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          if (adv) begin
            m_axi_bready <= 1'b1;
            cnt_q <= '0;
            st_q <= WR_B;
          end
        end
        WR_B: begin
          if (adv) begin
            m_axi_bready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp <= m_axi_bresp;
            rsp_timeout <= 1'b0;
            st_q <= RSP;
          end
        end
        RD_AR: begin
          if (adv) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready <= 1'b1;
            cnt_q <= '0;
            st_q <= RD_R;
          end
        end
        RD_R: begin
          if (adv) begin
            m_axi_rready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we <= 1'b0;
            rsp_rdata <= m_axi_rdata;
            rsp_resp <= m_axi_rresp;
            rsp_timeout <= 1'b0;
            st_q <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            st_q <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
      // a stuck slave is abandoned; anything it sends later is ignored since no ready stays high
      if (tmo_exit) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid <= 1'b0;
        m_axi_bready <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_we <= cur_q.we;
        rsp_rdata <= '0;
        rsp_resp <= 2'b10;
        rsp_timeout <= 1'b1;
        st_q <= RSP;
      end
    end
  end
endmodule

// File: tb/tb_axilite_m_queued.sv
// tb_axilite_m_queued: directed vector table plus hand sequences against a small AXI4-Lite slave model
module tb_axilite_m_queued;
  logic clk = 1'b0, rstn;
  logic cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_we, rsp_timeout, busy;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, awaddr, wdata, araddr, rdata;
  logic [3:0] cmd_wstrb, wstrb;
  logic [1:0] rsp_resp, bresp, rresp;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  int checks = 0, errors = 0;
  logic stall = 0, ar_never = 0, b_stall = 0, r_fixed = 1;
  int aw_lat = 0, w_lat = 0, aw_c = 0, w_c = 0;
  logic [1:0] b_resp_v = 0, r_resp_v = 0;
  logic [31:0] r_data_v = 0, cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0] cap_wstrb = 0;
  logic aw_got = 0, w_got = 0, ar_got = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0;

  axilite_m_queued #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rstn) begin
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (awvalid && awready) begin aw_got = 1; aw_hs++; cap_awaddr = awaddr; end
      if (wvalid && wready) begin w_got = 1; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
      if (bvalid && bready) begin aw_got = 0; w_got = 0; b_hs++; end
      if (arvalid && arready) begin ar_got = 1; cap_araddr = araddr; end
      if (rvalid && rready) ar_got = 0;
    end
  end

  always @(negedge clk) begin
    awready = awvalid && !stall && aw_c >= aw_lat;
    aw_c = awvalid ? aw_c + 1 : 0;
    wready = wvalid && !stall && w_c >= w_lat;
    w_c = wvalid ? w_c + 1 : 0;
    bvalid = aw_got && w_got && !stall && !b_stall;
    bresp = bvalid ? b_resp_v : 2'b00;
    arready = arvalid && !stall && !ar_never;
    rvalid = ar_got && !stall;
    rdata = !rvalid ? 32'h0 : r_fixed ? r_data_v : {16'hA5A5, cap_araddr[15:0]};
    rresp = rvalid ? r_resp_v : 2'b00;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input string nm, input logic we, input logic [31:0] d, input logic [1:0] r, input logic to);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, rsp_valid, 1);
    chk({nm, "_we"}, rsp_we, we);
    chk({nm, "_rdata"}, rsp_rdata, d);
    chk({nm, "_resp"}, rsp_resp, r);
    chk({nm, "_timeout"}, rsp_timeout, to);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_ctl"}, {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_we, rsp_resp, rsp_timeout, busy}, 0);
    chk({nm, "_addr"}, {awaddr, araddr}, 0);
    chk({nm, "_data"}, {wdata, rsp_rdata}, 0);
    chk({nm, "_strb"}, wstrb, 0);
    chk({nm, "_cmd_ready"}, cmd_ready, 0);
  endtask

  typedef struct {
    logic we; logic [31:0] addr, wdata; logic [3:0] strb;
    int aw_lat, w_lat; logic [1:0] sresp; logic [31:0] sdata;
    logic [31:0] e_rdata; logic [1:0] e_resp;
  } vec_t;
  vec_t tv[5];

  initial begin
    int a0, b0, n;
    logic seen;
    tv[0] = '{1, 32'h200, 32'hA1B2C3D4, 4'h3, 1, 1, 2'b00, 32'h0, 32'h0, 2'b00};
    tv[1] = '{0, 32'h20, 32'h0, 4'h0, 0, 0, 2'b10, 32'h12345678, 32'h12345678, 2'b10};
    tv[2] = '{1, 32'h204, 32'h0BADF00D, 4'h8, 0, 2, 2'b11, 32'h0, 32'h0, 2'b11};
    tv[3] = '{0, 32'h24, 32'h0, 4'h0, 0, 0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00};
    tv[4] = '{1, 32'h208, 32'hFFFFFFFF, 4'hF, 2, 0, 2'b01, 32'h0, 32'h0, 2'b01};
    rstn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk("reset");
    rstn = 1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    rsp_ready = 0;
    push(1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("lat_edge1_awvalid", awvalid, 0);
    @(negedge clk);
    chk("lat_edge2_aw_w_valid", {awvalid, wvalid}, 2'b11);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("rsp_hold_valid", rsp_valid, 1);
    chk("same_cycle_aw_w", {aw_hs, w_hs}, {32'd1, 32'd1});
    rsp_ready = 1;
    get_rsp("single_wr", 1, 0, 2'b00, 0);
    chk("single_wr_addr", {cap_awaddr, cap_wdata}, {32'h10, 32'hDEADBEEF});

    aw_lat = 3; w_lat = 0; a0 = aw_hs; b0 = b_hs; n = w_hs;
    push(1, 32'h14, 32'h11223344, 4'hF);
    while (w_hs == n && aw_hs == a0 && b_hs < 1000) @(negedge clk);
    chk("skew_w_first", {awvalid, wvalid}, 2'b10);
    get_rsp("skew_wr", 1, 0, 2'b00, 0);
    chk("skew_one_b", b_hs - b0, 1);
    chk("skew_one_aw", aw_hs - a0, 1);

    for (int i = 0; i < 5; i++) begin
      aw_lat = tv[i].aw_lat; w_lat = tv[i].w_lat; b_resp_v = tv[i].sresp; r_resp_v = tv[i].sresp;
      r_data_v = tv[i].sdata; b0 = b_hs;
      push(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].strb);
      get_rsp($sformatf("vec%0d", i), tv[i].we, tv[i].e_rdata, tv[i].e_resp, 0);
      if (tv[i].we) begin
        chk($sformatf("vec%0d_aw_w", i), {cap_awaddr, cap_wdata}, {tv[i].addr, tv[i].wdata});
        chk($sformatf("vec%0d_strb_b", i), {cap_wstrb, 4'(b_hs - b0)}, {tv[i].strb, 4'd1});
      end else chk($sformatf("vec%0d_araddr", i), cap_araddr, tv[i].addr);
    end

    aw_lat = 0; w_lat = 0; b_resp_v = 0; r_resp_v = 0; r_fixed = 0; stall = 1;
    for (int i = 0; i < 5; i++) push(0, 32'h100 + 32'(4 * i), 0, 0);
    chk("fill_full", cmd_ready, 0);
    chk("fill_busy", busy, 1);
    stall = 0;
    for (int i = 0; i < 5; i++) get_rsp($sformatf("fill%0d", i), 0, {16'hA5A5, 16'h100 + 16'(4 * i)}, 2'b00, 0);

    r_fixed = 1; r_data_v = 32'h77777777; ar_never = 1;
    push(0, 32'h30, 0, 0);
    push(1, 32'h34, 32'h55AA55AA, 4'hF);
    n = 0;
    while (!arvalid && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (arvalid && n < 100) begin n++; @(negedge clk); end
    chk("timeout_ar_cycles", n, 8);
    get_rsp("timeout", 0, 0, 2'b10, 1);
    ar_never = 0;
    get_rsp("after_timeout", 1, 0, 2'b00, 0);
    chk("after_timeout_addr", cap_awaddr, 32'h34);

    b_stall = 1;
    push(1, 32'h40, 32'h1, 4'hF);
    push(0, 32'h44, 0, 0);
    push(1, 32'h48, 32'h2, 4'hF);
    n = 0;
    while (!bready && n < 100) begin @(negedge clk); n++; end
    chk("mid_wr_b_bready", bready, 1);
    rstn = 0;
    @(negedge clk);
    rst_chk("mid_reset");
    rstn = 1; b_stall = 0;
    @(negedge clk);
    chk("mid_reset_idle", {cmd_ready, busy}, 2'b10);
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= rsp_valid | busy; end
    chk("mid_reset_no_rsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
